// File: rtl/special_op_dispatch.sv
// rtl/special_op_dispatch.sv - detects the custom opcode, launches the special-op PC unit and holds fetch until it is done
module special_op_dispatch #(
    parameter int          ADDRESS_BITS   = 20,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [6:0]  SPECIAL_OPCODE = 7'h0B,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [DATA_WIDTH-1:0]   instr,
    input  logic [ADDRESS_BITS-1:0] instr_pc,
    input  logic                    flush,
    input  logic                    spec_done,
    output logic                    spec_en,
    output logic [ADDRESS_BITS-1:0] spec_curr_pc,
    output logic                    pc_sel,
    output logic                    stall,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [CNT_WIDTH-1:0]    op_count
);

    localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESTORE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] to_cnt;
    logic          detect;
    logic          done_evt;
    logic          to_evt;
    logic          unused_instr_bits;

    assign unused_instr_bits = ^instr[DATA_WIDTH-1:7];

    assign detect = (state == S_IDLE) && instr_valid && (instr[6:0] == SPECIAL_OPCODE) && !flush;
    assign busy   = (state != S_IDLE);
    // Combinational so the triggering instruction is frozen in the same cycle it is seen.
    assign stall  = detect || busy;

    always_comb begin
        next_state = state;
        done_evt   = 1'b0;
        to_evt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (detect) next_state = S_LAUNCH;
            end
            S_LAUNCH: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes priority over a timeout on the same cycle.
                if (spec_done) begin
                    done_evt   = 1'b1;
                    next_state = S_RESTORE;
                end else if (to_cnt == TO_LAST) begin
                    to_evt     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_RESTORE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            spec_en      <= 1'b0;
            spec_curr_pc <= '0;
            pc_sel       <= 1'b0;
            timeout_err  <= 1'b0;
            op_count     <= '0;
        end else begin
            state   <= next_state;
            spec_en <= (next_state == S_LAUNCH);
            pc_sel  <= (next_state != S_IDLE);
            if (detect) spec_curr_pc <= instr_pc;
            if (state == S_LAUNCH) begin
                to_cnt <= '0;
            end else if (state == S_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_evt) timeout_err <= 1'b1;
            if (done_evt && (op_count != {CNT_WIDTH{1'b1}})) op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_special_op_dispatch.sv
// tb/tb_special_op_dispatch.sv - directed self-checking bench for special_op_dispatch
module tb_special_op_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [19:0] instr_pc;
    logic        flush;
    logic        spec_done;
    logic        spec_en;
    logic [19:0] spec_curr_pc;
    logic        pc_sel;
    logic        stall;
    logic        busy;
    logic        timeout_err;
    logic [15:0] op_count;

    int tests_run = 0;
    int tests_failed = 0;

    special_op_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .flush        (flush),
        .spec_done    (spec_done),
        .spec_en      (spec_en),
        .spec_curr_pc (spec_curr_pc),
        .pc_sel       (pc_sel),
        .stall        (stall),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_instr(input logic v, input logic [31:0] w, input logic [19:0] pc);
        instr_valid = v;
        instr       = w;
        instr_pc    = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0; flush = 1'b0; spec_done = 1'b0;
        do_reset();

        // reset state
        chk("rst_spec_en", {31'd0, spec_en}, 32'd0);
        chk("rst_pc_sel", {31'd0, pc_sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_count", {16'd0, op_count}, 32'd0);
        chk("rst_curr_pc", {12'd0, spec_curr_pc}, 32'd0);

        // T1 basic launch and completion
        drive_instr(1'b1, 32'h0000_000B, 20'h00100);
        chk("t1_stall_detect", {31'd0, stall}, 32'd1);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        chk("t1_spec_en", {31'd0, spec_en}, 32'd1);
        chk("t1_curr_pc", {12'd0, spec_curr_pc}, 32'h100);
        chk("t1_pc_sel_launch", {31'd0, pc_sel}, 32'd1);
        step();
        chk("t1_spec_en_drop", {31'd0, spec_en}, 32'd0);
        chk("t1_pc_sel_wait", {31'd0, pc_sel}, 32'd1);
        step(); step(); step();
        chk("t1_stall_wait", {31'd0, stall}, 32'd1);
        spec_done = 1'b1;
        step();
        spec_done = 1'b0;
        chk("t1_pc_sel_restore", {31'd0, pc_sel}, 32'd1);
        chk("t1_count", {16'd0, op_count}, 32'd1);
        chk("t1_busy_restore", {31'd0, busy}, 32'd1);
        step();
        chk("t1_pc_sel_release", {31'd0, pc_sel}, 32'd0);
        chk("t1_stall_release", {31'd0, stall}, 32'd0);
        chk("t1_curr_pc_hold", {12'd0, spec_curr_pc}, 32'h100);

        // T2 non-special stream never launches
        for (int i = 0; i < 4; i++) begin
            drive_instr(1'b1, 32'h0000_0033 | (i << 12), 20'h00200 + 20'(i * 4));
            chk("t2_stall", {31'd0, stall}, 32'd0);
            step();
            chk("t2_spec_en", {31'd0, spec_en}, 32'd0);
            chk("t2_pc_sel", {31'd0, pc_sel}, 32'd0);
        end
        drive_instr(1'b0, 32'h0, 20'h0);

        // T4 flush suppresses detection in IDLE, ignored while busy
        flush = 1'b1;
        drive_instr(1'b1, 32'h0000_008B, 20'h00150);
        chk("t4_stall_flush", {31'd0, stall}, 32'd0);
        step();
        chk("t4_no_launch", {31'd0, spec_en}, 32'd0);
        chk("t4_no_busy", {31'd0, busy}, 32'd0);
        flush = 1'b0;
        drive_instr(1'b1, 32'h0000_008B, 20'h00154);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        chk("t4_launch", {31'd0, spec_en}, 32'd1);
        chk("t4_curr_pc", {12'd0, spec_curr_pc}, 32'h154);
        step();
        flush = 1'b1;
        step(); step();
        chk("t4_busy_flush", {31'd0, busy}, 32'd1);
        spec_done = 1'b1;
        step();
        spec_done = 1'b0;
        flush = 1'b0;
        chk("t4_count", {16'd0, op_count}, 32'd2);
        step();
        chk("t4_idle", {31'd0, busy}, 32'd0);

        // T3 timeout after 64 WAIT cycles
        do_reset();
        drive_instr(1'b1, 32'h0000_000B, 20'h00300);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        step();
        for (int i = 0; i < 63; i++) step();
        chk("t3_busy_last", {31'd0, busy}, 32'd1);
        chk("t3_err_early", {31'd0, timeout_err}, 32'd0);
        step();
        chk("t3_err", {31'd0, timeout_err}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_pc_sel", {31'd0, pc_sel}, 32'd0);
        chk("t3_count", {16'd0, op_count}, 32'd0);
        spec_done = 1'b1;
        step();
        spec_done = 1'b0;
        chk("t3_done_idle_ignored", {16'd0, op_count}, 32'd0);
        chk("t3_err_sticky", {31'd0, timeout_err}, 32'd1);

        // T5 done on the timeout cycle wins, then back-to-back ops
        do_reset();
        chk("t5_err_cleared", {31'd0, timeout_err}, 32'd0);
        drive_instr(1'b1, 32'h0000_000B, 20'h00380);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        step();
        for (int i = 0; i < 63; i++) step();
        spec_done = 1'b1;
        step();
        spec_done = 1'b0;
        chk("t5_race_restore", {31'd0, pc_sel}, 32'd1);
        chk("t5_race_busy", {31'd0, busy}, 32'd1);
        chk("t5_race_err", {31'd0, timeout_err}, 32'd0);
        chk("t5_race_count", {16'd0, op_count}, 32'd1);
        step();
        drive_instr(1'b1, 32'h0000_000B, 20'h00200);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        chk("t5_b2b_first", {12'd0, spec_curr_pc}, 32'h200);
        step();
        spec_done = 1'b1;
        step();
        spec_done = 1'b0;
        drive_instr(1'b1, 32'h0000_000B, 20'h00204);
        chk("t5_no_detect_restore", {31'd0, spec_en}, 32'd0);
        step();
        chk("t5_idle_stall_detect", {31'd0, stall}, 32'd1);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        chk("t5_b2b_launch", {31'd0, spec_en}, 32'd1);
        chk("t5_b2b_second", {12'd0, spec_curr_pc}, 32'h204);
        step();
        spec_done = 1'b1;
        step();
        spec_done = 1'b0;
        step();
        chk("t5_count", {16'd0, op_count}, 32'd3);

        // T6 reset mid-operation
        drive_instr(1'b1, 32'h0000_000B, 20'h00500);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_pc_sel", {31'd0, pc_sel}, 32'd0);
        chk("t6_count", {16'd0, op_count}, 32'd0);
        chk("t6_curr_pc", {12'd0, spec_curr_pc}, 32'd0);
        chk("t6_stall", {31'd0, stall}, 32'd0);
        drive_instr(1'b1, 32'h0000_000B, 20'h00400);
        step();
        drive_instr(1'b0, 32'h0, 20'h0);
        chk("t6_relaunch", {31'd0, spec_en}, 32'd1);
        chk("t6_relaunch_pc", {12'd0, spec_curr_pc}, 32'h400);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
